// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART serializer
module uart_tx_buffered #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_busy
);

   localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CW = (SYMBOL_TIME > 1) ? $clog2(SYMBOL_TIME) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(SYMBOL_TIME - 1);
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   state_t        next_state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_next;
   logic [7:0]    shreg;
   logic          baud_done;
   logic          has_data;
   logic          push;
   logic          pop;
   logic          line_next;

   assign has_data      = count != '0;
   assign data_in_ready = count < DEPTH;
   assign push          = data_in_valid && data_in_ready;
   assign baud_done     = baud_cnt == BAUD_LAST;
   // Pop from IDLE or at the last STOP cycle so queued frames run back to back.
   assign pop           = has_data && ((state == IDLE) || (state == STOP && baud_done));
   assign fifo_count    = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (has_data) next_state = START;
         START: if (baud_done) next_state = DATA;
         DATA:  if (baud_done && bit_idx == 3'd7) next_state = STOP;
         STOP:  if (baud_done) next_state = has_data ? START : IDLE;
      endcase
   end

   always_comb begin
      tx_busy   = state != IDLE;
      bit_next  = (state == DATA && baud_done) ? bit_idx + 3'd1 : bit_idx;
      line_next = 1'b1;
      case (next_state)
         IDLE:  line_next = 1'b1;
         START: line_next = 1'b0;
         DATA:  line_next = shreg[bit_next];
         STOP:  line_next = 1'b1;
      endcase
   end

   // serial_out is registered from the next-state view so the line changes on the transition edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         serial_out <= 1'b1;
      end else begin
         if (next_state != state || baud_done) begin
            baud_cnt <= '0;
         end else if (state != IDLE) begin
            baud_cnt <= baud_cnt + 1'b1;
         end
         if (state == DATA && baud_done) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (pop) begin
            shreg <= mem[rd_ptr];
         end
         serial_out <= line_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d_data, f_data;
   logic       d_valid, f_valid;
   logic       d_ready, d_ser, d_busy;
   logic       f_ready, f_ser, f_busy;
   logic [3:0] d_count, f_count;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_buffered dut (
      .clk(clk), .rst(rst), .data_in(d_data), .data_in_valid(d_valid),
      .data_in_ready(d_ready), .serial_out(d_ser), .fifo_count(d_count), .tx_busy(d_busy)
   );

   uart_tx_buffered #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut_fast (
      .clk(clk), .rst(rst), .data_in(f_data), .data_in_valid(f_valid),
      .data_in_ready(f_ready), .serial_out(f_ser), .fifo_count(f_count), .tx_busy(f_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Receiver model for the fast instance: 10-cycle symbols, samples mid-symbol.
   initial begin
      logic [7:0] b;
      logic       start_bit, stop_bit;
      forever begin
         @(negedge clk);
         if (mon_en && f_ser === 1'b0) begin
            repeat (4) @(negedge clk);
            start_bit = f_ser;
            for (int i = 0; i < 8; i++) begin
               repeat (10) @(negedge clk);
               b[i] = f_ser;
            end
            repeat (10) @(negedge clk);
            stop_bit = f_ser;
            check("rx_start_bit", start_bit, 0);
            check("rx_stop_bit", stop_bit, 1);
            if (sb.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rx_unexpected_frame: got byte %02h, expected no frame", b);
            end else begin
               check("rx_byte", b, sb.pop_front());
            end
         end
      end
   end

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       exp_ready;
      logic [3:0] exp_count;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int p, c0, bad;
      bit found;

      for (int i = 0; i < 9; i++) begin
         vecs[i].data      = 8'(i);
         vecs[i].valid     = 1'b1;
         vecs[i].exp_ready = 1'b1;
         vecs[i].exp_count = (i == 0) ? 4'd1 : 4'(i);
      end
      vecs[9] = '{data: 8'hAA, valid: 1'b1, exp_ready: 1'b0, exp_count: 4'd8};

      rst = 1'b0;
      d_valid = 1'b0; d_data = 8'h00;
      f_valid = 1'b0; f_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_serial_out", d_ser, 1);
      check("rst_tx_busy", d_busy, 0);
      check("rst_fifo_count", d_count, 0);
      check("rst_ready", d_ready, 1);
      check("rst_fast_serial_out", f_ser, 1);
      check("rst_fast_tx_busy", f_busy, 0);
      check("rst_fast_fifo_count", f_count, 0);
      check("rst_fast_ready", f_ready, 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_release", d_busy, 0);
      mon_en = 1'b1;

      // 0x55 at default rates: every symbol checked at its first, middle and last cycle.
      d_data = 8'h55; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      p = cyc;
      check("lat_line_before_pop", d_ser, 1);
      check("lat_count_after_push", d_count, 1);
      for (int k = 0; k < 10; k++) begin
         logic       exp_bit;
         logic [7:0] pat;
         pat = 8'h55;
         exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : pat[k-1];
         wait_to(p + 1 + 434 * k);
         check($sformatf("sym%0d_first", k), d_ser, exp_bit);
         wait_to(p + 1 + 434 * k + 217);
         check($sformatf("sym%0d_mid", k), d_ser, exp_bit);
         wait_to(p + 434 * (k + 1));
         check($sformatf("sym%0d_last", k), d_ser, exp_bit);
      end
      check("frame_last_cycle_busy", d_busy, 1);
      wait_to(p + 4341);
      check("frame_end_line", d_ser, 1);
      check("frame_end_busy", d_busy, 0);

      // Nine back-to-back pushes, then a push offered while full.
      @(negedge clk);
      c0 = 0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("vec%0d_ready", i), f_ready, vecs[i].exp_ready);
         f_data  = vecs[i].data;
         f_valid = vecs[i].valid;
         if (vecs[i].valid && vecs[i].exp_ready) sb.push_back(vecs[i].data);
         @(negedge clk);
         if (i == 0) c0 = cyc;
         check($sformatf("vec%0d_count", i), f_count, vecs[i].exp_count);
      end

      // Full with valid held: first pop at STOP end must not be paired with a push.
      f_data = 8'h99;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (f_count != 4'd8) found = 1'b1;
      end
      check("full_pop_count", f_count, 7);
      check("full_pop_edge", cyc - c0, 101);
      check("full_pop_ready", f_ready, 1);
      sb.push_back(8'h99);
      @(negedge clk);
      f_valid = 1'b0;
      check("refill_count", f_count, 8);
      for (int i = 0; i < 2000 && f_busy; i++) @(negedge clk);
      check("ten_frames_no_gap", cyc - c0, 1001);
      check("sb_drained_1", sb.size(), 0);

      // Push coinciding with a pop while three bytes are queued.
      repeat (5) @(negedge clk);
      f_data = 8'h3C; f_valid = 1'b1; sb.push_back(8'h3C);
      @(negedge clk);
      p = cyc;
      check("fast_lat_line_before", f_ser, 1);
      f_data = 8'hA5; sb.push_back(8'hA5);
      @(negedge clk);
      check("fast_lat_line_start", f_ser, 0);
      check("fast_lat_busy", f_busy, 1);
      check("fast_push_pop_count", f_count, 1);
      f_data = 8'h0F; sb.push_back(8'h0F);
      @(negedge clk);
      f_data = 8'hF0; sb.push_back(8'hF0);
      @(negedge clk);
      f_valid = 1'b0;
      check("three_queued", f_count, 3);
      wait_to(p + 100);
      check("pre_concurrent_count", f_count, 3);
      f_data = 8'h81; f_valid = 1'b1; sb.push_back(8'h81);
      @(negedge clk);
      f_valid = 1'b0;
      check("concurrent_count", f_count, 3);
      check("concurrent_busy", f_busy, 1);
      for (int i = 0; i < 1000 && f_busy; i++) @(negedge clk);
      check("five_frames_len", cyc - p, 501);
      check("sb_drained_2", sb.size(), 0);

      // Reset in the middle of bit 4 with five bytes queued.
      repeat (5) @(negedge clk);
      mon_en = 1'b0;
      f_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         f_data = 8'hC0 + 8'(i);
         @(negedge clk);
         if (i == 0) p = cyc;
      end
      f_valid = 1'b0;
      wait_to(p + 55);
      check("pre_reset_count", f_count, 5);
      check("pre_reset_busy", f_busy, 1);
      rst = 1'b0;
      #1;
      check("mid_reset_line", f_ser, 1);
      check("mid_reset_count", f_count, 0);
      check("mid_reset_busy", f_busy, 0);
      check("mid_reset_ready", f_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (f_ser !== 1'b1 || f_busy !== 1'b0 || f_count !== 4'd0) bad++;
      end
      check("post_reset_quiet", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
